// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB slave register file.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic APB_OKAY = 1'b0;
  localparam logic APB_ERR  = 1'b1;

  localparam int MAX_DW = 128;
  localparam int MAX_SW = MAX_DW / 8;

  function automatic logic [MAX_DW-1:0] strb_merge(
    input logic [MAX_DW-1:0] old_d,
    input logic [MAX_DW-1:0] new_d,
    input logic [MAX_SW-1:0] strb
  );
    logic [MAX_DW-1:0] m;
    m = old_d;
    for (int k = 0; k < MAX_SW; k++) begin
      if (strb[k]) m[k*8 +: 8] = new_d[k*8 +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the master and the register-file slave.
interface apb_slave_regfile_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   paddr_i;
  logic [2:0]              pport_i;
  logic                    psel_i;
  logic                    penable_i;
  logic                    pwrite_i;
  logic [DATA_WIDTH-1:0]   pwdata_i;
  logic [DATA_WIDTH/8-1:0] pstrb_i;
  logic                    pready_o;
  logic [DATA_WIDTH-1:0]   prdata_o;
  logic                    pslverr_o;

  modport slave (
    input  paddr_i, pport_i, psel_i, penable_i,
    input  pwrite_i, pwdata_i, pstrb_i,
    output pready_o, prdata_o, pslverr_o
  );

  modport master (
    output paddr_i, pport_i, psel_i, penable_i,
    output pwrite_i, pwdata_i, pstrb_i,
    input  pready_o, prdata_o, pslverr_o
  );
endinterface

// File: rtl/apb_reg_bank.sv
// Register storage with byte-strobed writes and one-cycle write pulses.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_wr_en,
  input  logic [IDX_W-1:0]               i_index,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic [DATA_WIDTH/8-1:0]        i_strb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_reg_q,
  output logic [NUM_REGS-1:0]            o_reg_wr
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_wr;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_merged = DATA_WIDTH'(strb_merge(
    MAX_DW'(r_regs[i_index]),
    MAX_DW'(i_wdata),
    MAX_SW'(i_strb)));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_wr <= '0;
    end else begin
      r_wr <= '0;
      if (i_wr_en) begin
        r_regs[i_index] <= w_merged;
        r_wr[i_index]   <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign o_reg_q[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

  assign o_reg_wr = r_wr;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave: transfer FSM, wait counter, address decode and read mux.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 'hA9B0_0001
) (
  input  logic                           pclk_i,
  input  logic                           prst_i,
  apb_slave_regfile_if.slave             bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
  output logic [NUM_REGS-1:0]            reg_wr_o
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int SW    = DATA_WIDTH / 8;
  localparam int AW1   = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] LO = {1'b0, BASE_ADDR};
  localparam logic [AW1-1:0] HI = LO + AW1'(4 * NUM_REGS);

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic                  r_err;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [SW-1:0]         r_strb;

  logic [AW1-1:0]        w_addr;
  logic [AW1-1:0]        w_off;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_setup;
  logic                  w_err;
  logic                  w_done;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
  logic                  w_unused;

  assign w_addr  = {1'b0, bus.paddr_i};
  assign w_off   = w_addr - LO;
  assign w_idx   = w_off[IDX_W+1:2];
  assign w_setup = bus.psel_i & ~bus.penable_i;

  // Register 0 is the read-only ID, so writes to it are errors too.
  assign w_err = (bus.paddr_i[1:0] != 2'b00)
               | (w_addr < LO)
               | (w_addr >= HI)
               | (bus.pwrite_i & (w_idx == '0));

  assign w_done  = (r_state == RESP) & bus.psel_i & bus.penable_i;
  assign w_wr_en = w_done & r_write & (r_err == APB_OKAY);

  assign w_unused = ^{bus.pport_i, w_off};

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_setup) w_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: begin
        if (!bus.psel_i)     w_next = IDLE;
        else if (r_cnt == 4'd1) w_next = RESP;
      end
      RESP: begin
        if (!bus.psel_i || bus.penable_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.pready_o  = 1'b0;
    bus.pslverr_o = APB_OKAY;
    bus.prdata_o  = '0;
    if (r_state == RESP) begin
      bus.pready_o  = 1'b1;
      bus.pslverr_o = r_err;
      if (r_err == APB_OKAY && !r_write) bus.prdata_o = w_rdata;
    end
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_err   <= APB_OKAY;
      r_idx   <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if (r_state == IDLE && w_setup) begin
      r_cnt   <= 4'(WAIT_CYCLES);
      r_write <= bus.pwrite_i;
      r_err   <= w_err ? APB_ERR : APB_OKAY;
      r_idx   <= w_idx;
      r_wdata <= bus.pwdata_i;
      r_strb  <= bus.pstrb_i;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_unflat
    assign w_regs[g] = reg_q_o[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_rdata = (r_idx == '0) ? ID_VALUE : w_regs[r_idx];

  apb_reg_bank #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_bank (
    .i_clk    (pclk_i),
    .i_rst    (prst_i),
    .i_wr_en  (w_wr_en),
    .i_index  (r_idx),
    .i_wdata  (r_wdata),
    .i_strb   (r_strb),
    .o_reg_q  (reg_q_o),
    .o_reg_wr (reg_wr_o)
  );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: one slave with one wait state, one with zero wait states.
module tb_apb_slave_regfile;
  import apb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst0, sel;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [511:0] q1, q0;
  logic [15:0]  wr1, wr0;

  apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1();
  apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0();

  assign b1.paddr_i   = paddr;
  assign b1.pport_i   = 3'b000;
  assign b1.psel_i    = psel & ~sel;
  assign b1.penable_i = penable;
  assign b1.pwrite_i  = pwrite;
  assign b1.pwdata_i  = pwdata;
  assign b1.pstrb_i   = pstrb;
  assign b0.paddr_i   = paddr;
  assign b0.pport_i   = 3'b000;
  assign b0.psel_i    = psel & sel;
  assign b0.penable_i = penable;
  assign b0.pwrite_i  = pwrite;
  assign b0.pwdata_i  = pwdata;
  assign b0.pstrb_i   = pstrb;

  wire        pready  = sel ? b0.pready_o  : b1.pready_o;
  wire [31:0] prdata  = sel ? b0.prdata_o  : b1.prdata_o;
  wire        pslverr = sel ? b0.pslverr_o : b1.pslverr_o;

  apb_slave_regfile #(.WAIT_CYCLES(1)) dut1 (
    .pclk_i(clk), .prst_i(rst1), .bus(b1.slave),
    .reg_q_o(q1), .reg_wr_o(wr1)
  );

  apb_slave_regfile #(.WAIT_CYCLES(0)) dut0 (
    .pclk_i(clk), .prst_i(rst0), .bus(b0.slave),
    .reg_q_o(q0), .reg_wr_o(wr0)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the completing edge.
  task automatic xfer(input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      output logic [31:0] rd, output logic err,
                      output int cyc);
    psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = addr; pwdata = data; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1; cyc = 0; rd = '0; err = 1'b0;
    while (cyc < 20) begin
      cyc++;
      if (pready) begin
        rd = prdata; err = pslverr;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          cyc;

  initial begin
    sel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    rst1 = 1'b1; rst0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pready", 32'(b1.pready_o), 32'd0);
    chk("rst.pslverr", 32'(b1.pslverr_o), 32'd0);
    chk("rst.prdata", b1.prdata_o, 32'd0);
    rst1 = 1'b0; rst0 = 1'b0;
    @(posedge clk); #1;
    chk("rst.reg_wr", 32'(wr1), 32'd0);
    chk("rst.reg1", q1[32 +: 32], 32'd0);

    xfer(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, rd, err, cyc);
    chk("wr1.cycles", cyc, 32'd2);
    chk("wr1.err", 32'(err), 32'd0);
    chk("wr1.pulse", 32'(wr1), 32'h0002);
    chk("wr1.reg1", q1[32 +: 32], 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("wr1.pulse_end", 32'(wr1), 32'd0);

    xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, err, cyc);
    chk("rd1.cycles", cyc, 32'd2);
    chk("rd1.data", rd, 32'hDEADBEEF);
    chk("rd1.err", 32'(err), 32'd0);

    xfer(1'b1, 32'h4, 32'h11223344, 4'b0101, rd, err, cyc);
    chk("strb.reg1", q1[32 +: 32], 32'hDE22BE44);
    xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, err, cyc);
    chk("strb.rd", rd, 32'hDE22BE44);

    xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, err, cyc);
    chk("id.data", rd, 32'hA9B00001);
    chk("id.err", 32'(err), 32'd0);

    xfer(1'b1, 32'h0, 32'hFFFFFFFF, 4'hF, rd, err, cyc);
    chk("wr0.err", 32'(err), 32'd1);
    chk("wr0.cycles", cyc, 32'd2);
    chk("wr0.pulse", 32'(wr1), 32'd0);

    xfer(1'b0, 32'h40, 32'h0, 4'h0, rd, err, cyc);
    chk("oob.err", 32'(err), 32'd1);
    chk("oob.data", rd, 32'd0);
    xfer(1'b0, 32'h6, 32'h0, 4'h0, rd, err, cyc);
    chk("misal.err", 32'(err), 32'd1);
    chk("misal.data", rd, 32'd0);
    chk("err.reg1", q1[32 +: 32], 32'hDE22BE44);

    xfer(1'b1, 32'h8, 32'hCAFEF00D, 4'hF, rd, err, cyc);
    chk("wr2.reg2", q1[64 +: 32], 32'hCAFEF00D);

    // Abort: drop psel while the slave is waiting.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h8; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge clk); #1;
    psel = 1'b0;
    @(posedge clk); #1;
    chk("abort.state", 32'(dut1.r_state), 32'(IDLE));
    chk("abort.pready", 32'(b1.pready_o), 32'd0);
    chk("abort.pulse", 32'(wr1), 32'd0);
    @(posedge clk); #1;
    chk("abort.reg2", q1[64 +: 32], 32'hCAFEF00D);

    // Reset while a write sits in WAIT.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'hC; pwdata = 32'h00000055; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    rst1 = 1'b1;
    #1;
    chk("mrst.state", 32'(dut1.r_state), 32'(IDLE));
    chk("mrst.pready", 32'(b1.pready_o), 32'd0);
    chk("mrst.reg3", q1[96 +: 32], 32'd0);
    chk("mrst.reg1", q1[32 +: 32], 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst1 = 1'b0;
    @(posedge clk); #1;
    chk("mrst.reg3_after", q1[96 +: 32], 32'd0);
    xfer(1'b1, 32'hC, 32'h00000077, 4'hF, rd, err, cyc);
    chk("post.cycles", cyc, 32'd2);
    chk("post.pulse", 32'(wr1), 32'h0008);
    xfer(1'b0, 32'hC, 32'h0, 4'h0, rd, err, cyc);
    chk("post.rd", rd, 32'h00000077);

    // Zero-wait slave, back-to-back write/read/write.
    sel = 1'b1;
    xfer(1'b1, 32'h14, 32'hA5A5A5A5, 4'hF, rd, err, cyc);
    chk("z.wr.cycles", cyc, 32'd1);
    chk("z.wr.pulse", 32'(wr0), 32'h0020);
    xfer(1'b0, 32'h14, 32'h0, 4'h0, rd, err, cyc);
    chk("z.rd.cycles", cyc, 32'd1);
    chk("z.rd.data", rd, 32'hA5A5A5A5);
    xfer(1'b1, 32'h18, 32'h0F0F0F0F, 4'hF, rd, err, cyc);
    chk("z.wr2.cycles", cyc, 32'd1);
    chk("z.wr2.reg6", q0[192 +: 32], 32'h0F0F0F0F);
    chk("z.reg5", q0[160 +: 32], 32'hA5A5A5A5);
    xfer(1'b0, 32'h40, 32'h0, 4'h0, rd, err, cyc);
    chk("z.oob.err", 32'(err), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB slave with a small bank of software-visible 32-bit control/status registers, a programmable wait-state counter, and error responses. It sits directly downstream of the team's APB master on the same pclk domain. It decodes each transfer, inserts wait states, commits byte-strobed writes, returns read data, and flags illegal accesses with pslverr. Register contents and one-cycle write pulses are exported to the core logic.

## Interface
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width (multiple of 8)
- NUM_REGS, 16, number of registers (≥2), word-aligned from BASE_ADDR
- BASE_ADDR, 0, byte address of register 0
- WAIT_CYCLES, 1, wait states inserted per access (0..15)
- ID_VALUE, 32'hA9B0_0001, constant returned by read-only register 0

Clock and reset are fixed: one clock, `pclk_i`. Reset is asynchronous and active-high, `prst_i`.
- pclk_i  in  1  APB clock
- prst_i  in  1  asynchronous active-high reset
- paddr_i  in  ADDR_WIDTH  byte address
- pport_i  in  3  protection; accepted, ignored
- psel_i  in  1  slave select
- penable_i  in  1  access phase
- pwrite_i  in  1  1 = write
- pwdata_i  in  DATA_WIDTH  write data
- pstrb_i  in  DATA_WIDTH/8  byte-lane write enables
- pready_o  out  1  transfer completes this cycle
- prdata_o  out  DATA_WIDTH  read data, valid only while pready_o=1
- pslverr_o  out  1  error response, valid only while pready_o=1
- reg_q_o  out  NUM_REGS*DATA_WIDTH  flattened register contents; reg i is at [i*DATA_WIDTH +: DATA_WIDTH]
- reg_wr_o  out  NUM_REGS  one-cycle pulse per register after a committed write

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on psel_i & ~penable_i (setup phase), latch the address, write flag, wdata and strobes. Decode the error, load cnt=WAIT_CYCLES, and go to RESP if WAIT_CYCLES==0, else to WAIT.
- WAIT: cnt decrements each cycle. When cnt==1, go to RESP.
- RESP: pready_o=1. If psel_i & penable_i, the transfer completes: commit the write if there is no error, then go to IDLE.
- Abort: psel_i=0 in WAIT or RESP returns the FSM to IDLE with no write and no pulse.
- Error conditions (pslverr_o=1, no write, prdata_o=0):
  - paddr[1:0]≠0
  - paddr < BASE_ADDR
  - paddr ≥ BASE_ADDR + 4*NUM_REGS
  - write to register 0
- Index = (paddr − BASE_ADDR) >> 2.
- Write: byte lane k is updated only where pstrb[k]=1. reg_wr_o[index] pulses for one cycle after the commit, even if all strobes are 0.
- Read: register 0 returns ID_VALUE. Other registers return the current stored value.

## Timing
- Reset values:
  - state=IDLE, pready_o=0, pslverr_o=0, prdata_o=0, reg_wr_o=0
  - all registers 0; register 0 always reads ID_VALUE
- Outputs are decoded from registered state only. There is no combinational path from APB inputs to pready_o, pslverr_o or prdata_o.
- Latency: the access phase lasts WAIT_CYCLES+1 cycles, with pready_o high on the last one. With WAIT_CYCLES=0 this is a zero-wait transfer.
- Outside RESP: pready_o=0, prdata_o=0, pslverr_o=0.
- Written data is visible on reg_q_o in the cycle after completion. A read issued back-to-back after a write returns the new value.
- Back-to-back: the cycle after completion is IDLE. A setup phase presented in that cycle is accepted normally.
- Reset mid-transfer: the transfer is discarded and all outputs return to their reset values asynchronously.

## Structure
- Shared package apb_pkg:
  - state typedef (IDLE/WAIT/RESP)
  - APB_OKAY/APB_ERR response constants
  - strobe-merge function: old, new, strb → merged
- Sub-module apb_reg_bank: register storage plus strobed write and write-pulse generation. Its inputs are wr_en, index, wdata and strb. Its outputs are reg_q and reg_wr.
- The top level holds the FSM, wait counter, decode and read mux.

## Test plan
- WAIT_CYCLES=1: write 0xDEADBEEF to BASE+0x4 with strb 4'hF → pready high on the 2nd access cycle, pslverr=0, reg_wr_o[1] pulse, reg 1 = 0xDEADBEEF. A following read of 0x4 returns 0xDEADBEEF.
- Strobed write of 0x11223344 with strb 4'b0101 over 0xDEADBEEF → reg 1 = 0xDE22BE44.
- Read 0x0 → ID_VALUE. Write 0x0 → pslverr=1, reg_wr_o stays 0.
- Read BASE+0x40 (NUM_REGS=16) and read 0x6 → pslverr=1, prdata=0, no state change.
- WAIT_CYCLES=0: back-to-back write/read/write → each completes in its first access cycle with no idle gap beyond the IDLE cycle.
- Assert prst_i during WAIT of a write → no register change, pready_o=0, FSM in IDLE. The next transfer works normally.
